// File: rtl/wam_hit.sv
// Whack-a-mole player input stage: synchronise and debounce the hole buttons,
// classify presses as hits or misses, keep BCD score/miss counters, run the game FSM.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for a start rising edge; counters hold the last game
// ST_PLAY | presses classified, hit pulses driven, counters advance
// ST_OVER | game ended on miss limit or full score; counters held
module wam_hit #(
    parameter int unsigned DEB_CYC  = 3,
    parameter logic [7:0]  MAX_MISS = 8'h09
) (
    input  logic       clk_19,
    input  logic       clr,
    input  logic       start,
    input  logic [7:0] btn,
    input  logic [7:0] holes,
    output logic [7:0] hit,
    output logic [7:0] score,
    output logic [7:0] miss,
    output logic       playing,
    output logic       over
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam logic [3:0] DEB_LAST = 4'(DEB_CYC - 1);

    logic [7:0] s1_q, s2_q;
    logic [7:0] db_q, db_d;
    logic [3:0] cnt_q [8];
    logic [3:0] cnt_d [8];
    logic [7:0] press_q, press_d;
    logic [7:0] hit_q, hit_d;
    logic [7:0] missed;
    logic [7:0] score_q, score_d;
    logic [7:0] miss_q, miss_d;
    logic       start_q;
    logic       start_rise;
    state_t     state_q, state_d;
    logic       playing_q, playing_d;
    logic       over_q, over_d;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Adds 0..8 to a 2-digit BCD value, pinning at 99.
    function automatic logic [7:0] bcd_add_sat(input logic [7:0] v, input logic [3:0] n);
        logic [4:0] u;
        logic [4:0] t;
        u = {1'b0, v[3:0]} + {1'b0, n};
        t = {1'b0, v[7:4]};
        if (u > 5'd9) begin
            u = u - 5'd10;
            t = t + 5'd1;
        end
        if (t > 5'd9) begin
            return 8'h99;
        end
        return {t[3:0], u[3:0]};
    endfunction

    always_comb begin
        db_d    = db_q;
        press_d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = 4'd0;
            end else if (cnt_q[i] == DEB_LAST) begin
                db_d[i]    = s2_q[i];
                cnt_d[i]   = 4'd0;
                press_d[i] = s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end
        end
    end

    assign start_rise = start & ~start_q;

    always_comb begin
        state_d = state_q;
        hit_d   = 8'h00;
        missed  = 8'h00;
        score_d = score_q;
        miss_d  = miss_q;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_PLAY;
                    score_d = 8'h00;
                    miss_d  = 8'h00;
                end
            end
            ST_PLAY: begin
                hit_d   = press_q & holes;
                missed  = press_q & ~holes;
                score_d = bcd_add_sat(score_q, popcount8(hit_d));
                miss_d  = bcd_add_sat(miss_q, popcount8(missed));
                // end test uses post-update values so the last press is counted
                if ((miss_d >= MAX_MISS) || (score_d == 8'h99)) begin
                    state_d = ST_OVER;
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        playing_d = (state_d == ST_PLAY);
        over_d    = (state_d == ST_OVER);
    end

    always_ff @(posedge clk_19 or posedge clr) begin
        if (clr) begin
            s1_q      <= 8'h00;
            s2_q      <= 8'h00;
            db_q      <= 8'h00;
            press_q   <= 8'h00;
            hit_q     <= 8'h00;
            score_q   <= 8'h00;
            miss_q    <= 8'h00;
            start_q   <= 1'b0;
            state_q   <= ST_IDLE;
            playing_q <= 1'b0;
            over_q    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= 4'd0;
            end
        end else begin
            s1_q      <= btn;
            s2_q      <= s1_q;
            db_q      <= db_d;
            press_q   <= press_d;
            hit_q     <= hit_d;
            score_q   <= score_d;
            miss_q    <= miss_d;
            start_q   <= start;
            state_q   <= state_d;
            playing_q <= playing_d;
            over_q    <= over_d;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign hit     = hit_q;
    assign score   = score_q;
    assign miss    = miss_q;
    assign playing = playing_q;
    assign over    = over_q;

endmodule

// File: tb/tb_wam_hit.sv
// Bench for wam_hit: integer-level game model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_wam_hit;

    localparam int DEB = 3;

    logic       clk_19 = 1'b0;
    logic       clr    = 1'b0;
    logic       start  = 1'b0;
    logic [7:0] btn    = 8'h00;
    logic [7:0] holes  = 8'h00;
    logic [7:0] hit, score, miss;
    logic       playing, over;

    int total = 0;
    int bad   = 0;

    wam_hit #(.DEB_CYC(DEB), .MAX_MISS(8'h09)) dut (
        .clk_19 (clk_19),
        .clr    (clr),
        .start  (start),
        .btn    (btn),
        .holes  (holes),
        .hit    (hit),
        .score  (score),
        .miss   (miss),
        .playing(playing),
        .over   (over)
    );

    always #5 clk_19 = ~clk_19;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: button histories, stable-run lengths, integer score/miss, game phase.
    logic [7:0] m_s1, m_s2, m_db, m_press, m_hit;
    int         m_run [8];
    int         m_sc, m_ms, m_st;
    logic       m_start_prev;
    logic [7:0] t_press, t_db, t_hit;
    int         t_sc, t_ms, t_st;
    logic       t_rise;

    always @(posedge clk_19 or posedge clr) begin
        if (clr) begin
            m_s1 = 0; m_s2 = 0; m_db = 0; m_press = 0; m_hit = 0;
            m_sc = 0; m_ms = 0; m_st = 0; m_start_prev = 0;
            for (int i = 0; i < 8; i++) m_run[i] = 0;
        end else begin
            t_press = 8'h00;
            t_db    = m_db;
            for (int i = 0; i < 8; i++) begin
                if (m_s2[i] == m_db[i]) begin
                    m_run[i] = 0;
                end else if (m_run[i] + 1 >= DEB) begin
                    t_db[i]    = m_s2[i];
                    t_press[i] = m_s2[i];
                    m_run[i]   = 0;
                end else begin
                    m_run[i] = m_run[i] + 1;
                end
            end
            t_rise = start && !m_start_prev;
            t_hit = 8'h00; t_sc = m_sc; t_ms = m_ms; t_st = m_st;
            if (m_st == 0) begin
                if (t_rise) begin t_st = 1; t_sc = 0; t_ms = 0; end
            end else if (m_st == 1) begin
                t_hit = m_press & holes;
                t_sc  = m_sc + $countones(t_hit);
                t_ms  = m_ms + $countones(m_press & ~holes);
                if (t_sc > 99) t_sc = 99;
                if (t_ms > 99) t_ms = 99;
                if (t_ms >= 9 || t_sc == 99) t_st = 2;
            end else begin
                if (t_rise) t_st = 0;
            end
            m_s2 = m_s1; m_s1 = btn; m_db = t_db; m_press = t_press;
            m_hit = t_hit; m_sc = t_sc; m_ms = t_ms; m_st = t_st;
            m_start_prev = start;
        end
    end

    always @(negedge clk_19) begin
        chk("m_hit", hit, m_hit);
        chk("m_score", score, to_bcd(m_sc));
        chk("m_miss", miss, to_bcd(m_ms));
        chk("m_playing", {7'd0, playing}, {7'd0, m_st == 1});
        chk("m_over", {7'd0, over}, {7'd0, m_st == 2});
    end

    task automatic step();
        @(posedge clk_19);
        #2;
    endtask

    task automatic press(input logic [7:0] b, input int hold, output int nhit, output int first,
                         output logic [7:0] hv, output logic [7:0] sv, output logic [7:0] mv);
        btn = b; nhit = 0; first = 0; hv = 0; sv = 0; mv = 0;
        for (int e = 1; e <= hold; e++) begin
            step();
            if (hit != 8'h00) begin
                nhit++;
                if (first == 0) begin first = e; hv = hit; sv = score; mv = miss; end
            end
        end
        btn = 8'h00;
        repeat (8) step();
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0; step();
    endtask

    int nh, fe;
    logic [7:0] hv, sv, mv;

    initial begin
        #1 clr = 1'b1;
        #21 clr = 1'b0;
        step();
        chk("rst_hit", hit, 8'h00);
        chk("rst_score", score, 8'h00);
        chk("rst_miss", miss, 8'h00);
        chk("rst_playing", {7'd0, playing}, 8'h00);
        chk("rst_over", {7'd0, over}, 8'h00);

        start = 1'b1; step();
        chk("start_playing", {7'd0, playing}, 8'h01);
        chk("start_score", score, 8'h00);
        start = 1'b0; step();

        holes = 8'h04;
        press(8'h04, 20, nh, fe, hv, sv, mv);
        chk_int("clean_count", nh, 1);
        chk_int("clean_edge", fe, 6);
        chk("clean_hit", hv, 8'h04);
        chk("clean_score", score, 8'h01);

        holes = 8'h20;
        btn = 8'h20; step(); btn = 8'h00; step(); btn = 8'h20; step(); btn = 8'h00; step();
        btn = 8'h20; nh = 0; fe = 0;
        for (int e = 5; e <= 20; e++) begin
            step();
            if (hit != 8'h00) begin nh++; if (fe == 0) fe = e; end
        end
        btn = 8'h00; repeat (8) step();
        chk_int("bounce_count", nh, 1);
        chk_int("bounce_edge", fe, 10);
        chk("bounce_score", score, 8'h02);

        holes = 8'h03;
        press(8'h07, 8, nh, fe, hv, sv, mv);
        chk_int("simul_edge", fe, 6);
        chk("simul_hit", hv, 8'h03);
        chk("simul_score", sv, 8'h04);
        chk("simul_miss", mv, 8'h01);

        holes = 8'h01;
        for (int k = 5; k <= 12; k++) begin
            press(8'h01, 8, nh, fe, hv, sv, mv);
            chk("bcd_score", score, to_bcd(k));
        end
        chk("bcd_12", score, 8'h12);

        holes = 8'hFF;
        for (int k = 1; k <= 10; k++) press(8'hFF, 8, nh, fe, hv, sv, mv);
        chk("sat_92", score, 8'h92);
        press(8'h3F, 8, nh, fe, hv, sv, mv);
        chk("sat_98", score, 8'h98);
        press(8'h03, 8, nh, fe, hv, sv, mv);
        chk("sat_99_edge", sv, 8'h99);
        chk("sat_over", {7'd0, over}, 8'h01);
        chk("sat_playing", {7'd0, playing}, 8'h00);
        chk("sat_miss", miss, 8'h01);

        pulse_start();
        chk("idle_over", {7'd0, over}, 8'h00);
        chk("idle_playing", {7'd0, playing}, 8'h00);
        chk("idle_score_held", score, 8'h99);
        start = 1'b1; step();
        chk("restart_playing", {7'd0, playing}, 8'h01);
        chk("restart_score", score, 8'h00);
        chk("restart_miss", miss, 8'h00);
        start = 1'b0; step();

        holes = 8'h00;
        press(8'h07, 8, nh, fe, hv, sv, mv);
        press(8'h07, 8, nh, fe, hv, sv, mv);
        chk("miss_6", miss, 8'h06);
        btn = 8'h07;
        repeat (5) step();
        chk("miss_pre", miss, 8'h06);
        chk("over_pre", {7'd0, over}, 8'h00);
        step();
        chk("miss_9", miss, 8'h09);
        chk("over_9", {7'd0, over}, 8'h01);
        btn = 8'h00; repeat (8) step();

        holes = 8'hFF;
        press(8'hFF, 8, nh, fe, hv, sv, mv);
        chk_int("over_nohit", nh, 0);
        chk("over_score_frozen", score, 8'h00);
        chk("over_miss_frozen", miss, 8'h09);

        pulse_start();
        pulse_start();
        chk("again_playing", {7'd0, playing}, 8'h01);
        chk("again_miss", miss, 8'h00);

        holes = 8'h01;
        press(8'h01, 8, nh, fe, hv, sv, mv);
        chk("pre_clr_score", score, 8'h01);
        holes = 8'hFF; btn = 8'hFF;
        repeat (4) step();
        #1 clr = 1'b1;
        #1;
        chk("clr_hit", hit, 8'h00);
        chk("clr_score", score, 8'h00);
        chk("clr_miss", miss, 8'h00);
        chk("clr_playing", {7'd0, playing}, 8'h00);
        chk("clr_over", {7'd0, over}, 8'h00);
        btn = 8'h00;
        #10 clr = 1'b0;
        nh = 0;
        for (int e = 0; e < 12; e++) begin
            step();
            if (hit != 8'h00) nh++;
        end
        chk_int("clr_nohit", nh, 0);

        pulse_start();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) btn = btn ^ 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) holes = 8'($urandom);
            start = ($urandom_range(0, 40) == 0);
            step();
        end
        start = 1'b0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
